// File: rtl/mc_main_fsm.sv
// Multi-cycle RV32I main controller: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives datapath selects/enables.
module mc_main_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [2:0] ImmSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       instr_retire,
  output logic       illegal_instr
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEMADR    = 4'd2,
    MEMREAD   = 4'd3,
    MEMWB     = 4'd4,
    MEMWRITE  = 4'd5,
    EXECR     = 4'd6,
    EXECI     = 4'd7,
    ALUWB     = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10,
    JALR_ADR  = 4'd11,
    JALR_LINK = 4'd12,
    LUI       = 4'd13,
    TRAP      = 4'd14
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_irwrite, w_pcwrite, w_regwrite, w_memwrite, w_retire, w_illegal;
  logic   w_take;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= state_t'(RESET_STATE);
    else          r_state <= w_next;
  end

  always_comb begin
    w_take = 1'b0;
    unique case (funct3)
      3'b000: w_take = Zero;
      3'b001: w_take = !Zero;
      3'b100: w_take = lt;
      3'b101: w_take = !lt;
      3'b110: w_take = ltu;
      3'b111: w_take = !ltu;
      default: w_take = 1'b0;
    endcase
  end

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      7'b0100011:             ImmSrc = 3'b001;
      7'b1100011:             ImmSrc = 3'b010;
      7'b1101111:             ImmSrc = 3'b011;
      7'b0110111, 7'b0010111: ImmSrc = 3'b100;
      default:                ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    ALUOp      = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    AdrSrc     = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_retire   = 1'b0;
    w_illegal  = 1'b0;
    unique case (r_state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
        if (mem_ready) w_next = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: w_next = MEMADR;
          7'b0110011:             w_next = EXECR;
          7'b0010011:             w_next = EXECI;
          7'b1100011:             w_next = BRANCH;
          7'b1101111:             w_next = JAL;
          7'b1100111:             w_next = JALR_ADR;
          7'b0110111:             w_next = LUI;
          7'b0010111:             w_next = ALUWB;
          default:                w_next = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) w_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
        w_retire   = mem_ready;
        if (mem_ready) w_next = FETCH;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        w_next  = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        w_next  = ALUWB;
      end
      ALUWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = FETCH;
      end
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUOp     = 2'b01;
        w_pcwrite = w_take;
        w_retire  = 1'b1;
        w_next    = FETCH;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = ALUWB;
      end
      JALR_ADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = JALR_LINK;
      end
      JALR_LINK: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = ALUWB;
      end
      LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        w_next  = ALUWB;
      end
      TRAP: begin
        w_illegal = 1'b1;
      end
      default: w_next = TRAP;
    endcase
  end

  // Gate with reset_n so enables drop as soon as reset asserts, without a clock.
  assign IRWrite       = w_irwrite  & reset_n;
  assign PCWrite       = w_pcwrite  & reset_n;
  assign RegWrite      = w_regwrite & reset_n;
  assign MemWrite      = w_memwrite & reset_n;
  assign instr_retire  = w_retire   & reset_n;
  assign illegal_instr = w_illegal  & reset_n;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed cycle-by-cycle vector bench for mc_main_fsm.
module tb_mc_main_fsm;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       Zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
  logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
  logic       AdrSrc;
  logic [2:0] ImmSrc;
  logic       IRWrite, PCWrite, RegWrite, MemWrite, instr_retire, illegal_instr;

  int total = 0;
  int bad = 0;

  mc_main_fsm #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3),
    .Zero(Zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .ImmSrc(ImmSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .instr_retire(instr_retire),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011,
                         OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                         OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_BAD = 7'b1111111;

  // exp = {ALUOp,ALUSrcA,ALUSrcB,ResultSrc,AdrSrc,ImmSrc,IRW,PCW,RegW,MemW,retire,illegal}
  typedef struct {
    string       nm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [3:0]  fl;   // {Zero,lt,ltu,mem_ready}
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [17:0] act();
    return {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ImmSrc,
            IRWrite, PCWrite, RegWrite, MemWrite, instr_retire, illegal_instr};
  endfunction

  task automatic chk(input string nm, input logic [17:0] a, input logic [17:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, a, e);
    end
  endtask

  task automatic v(input string nm, input logic [6:0] o, input logic [2:0] f3,
                   input logic [3:0] fl, input logic [1:0] aop, input logic [1:0] sa,
                   input logic [1:0] sb, input logic [1:0] rs, input logic adr,
                   input logic [2:0] imm, input logic [3:0] en, input logic ret,
                   input logic ill);
    vec_t x;
    x.nm = nm; x.op = o; x.f3 = f3; x.fl = fl;
    x.exp = {aop, sa, sb, rs, adr, imm, en, ret, ill};
    vecs.push_back(x);
  endtask

  task automatic fetch(input logic [6:0] o, input logic [2:0] imm);
    v("fetch", o, 3'b000, 4'b0001, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0, imm, 4'b1100, 1'b0, 1'b0);
  endtask

  task automatic dec(input logic [6:0] o, input logic [2:0] imm);
    v("decode", o, 3'b000, 4'b0001, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, imm, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic aluwb(input logic [6:0] o, input logic [2:0] imm);
    v("aluwb", o, 3'b000, 4'b0001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, imm, 4'b0010, 1'b1, 1'b0);
  endtask

  task automatic br(input logic [2:0] f3, input logic [3:0] fl, input logic take);
    fetch(OP_B, 3'b010);
    dec(OP_B, 3'b010);
    v("branch", OP_B, f3, fl, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 3'b010,
      {1'b0, take, 2'b00}, 1'b1, 1'b0);
  endtask

  initial begin
    // R-type add
    fetch(OP_R, 3'b000);
    dec(OP_R, 3'b000);
    v("execr", OP_R, 3'b000, 4'b0001, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0);
    aluwb(OP_R, 3'b000);
    // lw with three stalled MEMREAD cycles
    fetch(OP_LW, 3'b000);
    dec(OP_LW, 3'b000);
    v("memadr_l", OP_LW, 3'b000, 4'b0001, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      v("memread_stall", OP_LW, 3'b000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 4'b0000, 1'b0, 1'b0);
    v("memread_rdy", OP_LW, 3'b000, 4'b0001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 4'b0000, 1'b0, 1'b0);
    v("memwb", OP_LW, 3'b000, 4'b0001, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 4'b0010, 1'b1, 1'b0);
    // sw with a stalled fetch and a stalled write
    v("fetch_stall", OP_SW, 3'b000, 4'b0000, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b001, 4'b0000, 1'b0, 1'b0);
    fetch(OP_SW, 3'b001);
    dec(OP_SW, 3'b001);
    v("memadr_s", OP_SW, 3'b000, 4'b0001, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b001, 4'b0000, 1'b0, 1'b0);
    v("memwr_stall", OP_SW, 3'b000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b001, 4'b0001, 1'b0, 1'b0);
    v("memwr_rdy", OP_SW, 3'b000, 4'b0001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b001, 4'b0001, 1'b1, 1'b0);
    // branches: {Zero,lt,ltu,mem_ready}
    br(3'b001, 4'b0001, 1'b1);
    br(3'b001, 4'b1001, 1'b0);
    br(3'b110, 4'b0011, 1'b1);
    br(3'b010, 4'b1111, 1'b0);
    br(3'b101, 4'b0001, 1'b1);
    br(3'b000, 4'b1001, 1'b1);
    br(3'b100, 4'b0011, 1'b0);
    // jalr
    fetch(OP_JALR, 3'b000);
    dec(OP_JALR, 3'b000);
    v("jalr_adr", OP_JALR, 3'b000, 4'b0001, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0);
    v("jalr_link", OP_JALR, 3'b000, 4'b0001, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 3'b000, 4'b0100, 1'b0, 1'b0);
    aluwb(OP_JALR, 3'b000);
    // jal
    fetch(OP_JAL, 3'b011);
    dec(OP_JAL, 3'b011);
    v("jal", OP_JAL, 3'b000, 4'b0001, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 3'b011, 4'b0100, 1'b0, 1'b0);
    aluwb(OP_JAL, 3'b011);
    // lui
    fetch(OP_LUI, 3'b100);
    dec(OP_LUI, 3'b100);
    v("lui", OP_LUI, 3'b000, 4'b0001, 2'b00, 2'b11, 2'b01, 2'b00, 1'b0, 3'b100, 4'b0000, 1'b0, 1'b0);
    aluwb(OP_LUI, 3'b100);
    // auipc: straight from DECODE to ALUWB
    fetch(OP_AUIPC, 3'b100);
    dec(OP_AUIPC, 3'b100);
    aluwb(OP_AUIPC, 3'b100);
    // I-type
    fetch(OP_I, 3'b000);
    dec(OP_I, 3'b000);
    v("execi", OP_I, 3'b000, 4'b0001, 2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0);
    aluwb(OP_I, 3'b000);
    // illegal opcode, TRAP must absorb
    fetch(OP_BAD, 3'b000);
    dec(OP_BAD, 3'b000);
    for (int i = 0; i < 12; i++)
      v("trap", OP_BAD, 3'b000, 4'b0001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1);

    // reset state with mem_ready high: FETCH selects, enables gated
    op = OP_R; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", act(),
           {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0});
    @(negedge clk) reset_n = 1'b1;

    foreach (vecs[i]) begin
      op = vecs[i].op; funct3 = vecs[i].f3;
      {Zero, lt, ltu, mem_ready} = vecs[i].fl;
      #1 chk($sformatf("%s[%0d]", vecs[i].nm, i), act(), vecs[i].exp);
      @(posedge clk); #1;
    end

    // TRAP clears asynchronously on reset
    reset_n = 1'b0;
    #1 chk("trap_reset", act(),
           {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0});
    @(negedge clk) reset_n = 1'b1;

    // reset while MemWrite held in a stalled MEMWRITE
    op = OP_SW; funct3 = '0; {Zero, lt, ltu} = '0; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("memwr_before_rst", act(),
        {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b001, 4'b0001, 1'b0, 1'b0});
    reset_n = 1'b0;
    #1 chk("memwr_async_drop", act(),
           {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b001, 4'b0000, 1'b0, 1'b0});
    mem_ready = 1'b1;
    #1 chk("irwrite_gated_in_rst", act(),
           {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b001, 4'b0000, 1'b0, 1'b0});
    @(negedge clk) reset_n = 1'b1;
    #1 chk("fetch_after_rst", act(),
           {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b001, 4'b1100, 1'b0, 1'b0});
    @(posedge clk); #1;
    chk("decode_after_rst", act(),
        {2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b001, 4'b0000, 1'b0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
